// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALUOp codes,
// control-word layout and the bubble constant.
package mips_pkg;

  typedef enum logic [1:0] {
    ALUOP_RTYPE = 2'b00,
    ALUOP_JUMP  = 2'b01,
    ALUOP_NOP   = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluOpE;

  localparam int C_REG_DST    = 0;
  localparam int C_ALU_SRC    = 1;
  localparam int C_MEM_TO_REG = 2;
  localparam int C_REG_WRITE  = 3;
  localparam int C_MEM_READ   = 4;
  localparam int C_MEM_WRITE  = 5;
  localparam int C_BRANCH     = 6;
  localparam int C_JUMP       = 7;
  localparam int C_SIGN_ZERO  = 8;
  localparam int C_ALU_OP_LO  = 9;
  localparam int C_ALU_OP_HI  = 10;
  localparam int CTRL_W       = 11;

  typedef logic [CTRL_W-1:0] ctrlT;

  localparam ctrlT CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX
// and the instruction sitting in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  output logic              stall
);

  logic rtMatch;

  // $zero is hardwired, so a load into it never creates a dependency
  assign rtMatch = (exRt != '0) &&
                   ((exRt == idRs) || (exRt == idRt));

  assign stall = exValid && exMemRead && idValid && rtMatch;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall,
// bubble insertion, flush and stall-event counter.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_reg_dst,
  input  logic                   id_alu_src,
  input  logic                   id_mem_to_reg,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   id_branch,
  input  logic                   id_jump,
  input  logic                   id_sign_zero,
  input  logic [1:0]             id_alu_op,
  input  logic [DATA_W-1:0]      id_rd1,
  input  logic [DATA_W-1:0]      id_rd2,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic [DATA_W-1:0]      id_pc4,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   ex_flush,
  output logic                   ex_valid,
  output logic                   ex_reg_dst,
  output logic                   ex_alu_src,
  output logic                   ex_mem_to_reg,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic                   ex_jump,
  output logic                   ex_sign_zero,
  output logic [1:0]             ex_alu_op,
  output logic [DATA_W-1:0]      ex_rd1,
  output logic [DATA_W-1:0]      ex_rd2,
  output logic [DATA_W-1:0]      ex_imm,
  output logic [DATA_W-1:0]      ex_pc4,
  output logic [REG_AW-1:0]      ex_rs,
  output logic [REG_AW-1:0]      ex_rt,
  output logic [REG_AW-1:0]      ex_rd,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ctrlT idCtrl;
  ctrlT exCtrl;
  ctrlT nxtCtrl;

  logic              validQ;
  logic              nxtValid;
  logic [DATA_W-1:0] rd1Q, rd2Q, immQ, pc4Q;
  logic [DATA_W-1:0] nxtRd1, nxtRd2, nxtImm, nxtPc4;
  logic [REG_AW-1:0] rsQ, rtQ, rdQ;
  logic [REG_AW-1:0] nxtRs, nxtRt, nxtRd;
  logic              hazard;
  logic              load;

  logic [STALL_CNT_W-1:0] stallCnt;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) uHazard (
    .exValid  (validQ),
    .exMemRead(exCtrl[C_MEM_READ]),
    .exRt     (rtQ),
    .idValid  (id_valid),
    .idRs     (id_rs),
    .idRt     (id_rt),
    .stall    (hazard)
  );

  assign stall = hazard;
  assign load  = !ex_flush && !hazard;

  always_comb begin
    idCtrl                          = CTRL_BUBBLE;
    idCtrl[C_REG_DST]               = id_reg_dst;
    idCtrl[C_ALU_SRC]               = id_alu_src;
    idCtrl[C_MEM_TO_REG]            = id_mem_to_reg;
    idCtrl[C_REG_WRITE]             = id_reg_write;
    idCtrl[C_MEM_READ]              = id_mem_read;
    idCtrl[C_MEM_WRITE]             = id_mem_write;
    idCtrl[C_BRANCH]                = id_branch;
    idCtrl[C_JUMP]                  = id_jump;
    idCtrl[C_SIGN_ZERO]             = id_sign_zero;
    idCtrl[C_ALU_OP_HI:C_ALU_OP_LO] = id_alu_op;
  end

  // flush and stall both load a fully zeroed bubble
  always_comb begin
    nxtCtrl  = CTRL_BUBBLE;
    nxtValid = 1'b0;
    nxtRd1   = '0;
    nxtRd2   = '0;
    nxtImm   = '0;
    nxtPc4   = '0;
    nxtRs    = '0;
    nxtRt    = '0;
    nxtRd    = '0;
    if (load) begin
      nxtCtrl  = id_valid ? idCtrl : CTRL_BUBBLE;
      nxtValid = id_valid;
      nxtRd1   = id_rd1;
      nxtRd2   = id_rd2;
      nxtImm   = id_imm;
      nxtPc4   = id_pc4;
      nxtRs    = id_rs;
      nxtRt    = id_rt;
      nxtRd    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exCtrl <= CTRL_BUBBLE;
      validQ <= 1'b0;
      rd1Q   <= '0;
      rd2Q   <= '0;
      immQ   <= '0;
      pc4Q   <= '0;
      rsQ    <= '0;
      rtQ    <= '0;
      rdQ    <= '0;
    end else begin
      exCtrl <= nxtCtrl;
      validQ <= nxtValid;
      rd1Q   <= nxtRd1;
      rd2Q   <= nxtRd2;
      immQ   <= nxtImm;
      pc4Q   <= nxtPc4;
      rsQ    <= nxtRs;
      rtQ    <= nxtRt;
      rdQ    <= nxtRd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (hazard && !ex_flush && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign ex_valid      = validQ;
  assign ex_reg_dst    = exCtrl[C_REG_DST];
  assign ex_alu_src    = exCtrl[C_ALU_SRC];
  assign ex_mem_to_reg = exCtrl[C_MEM_TO_REG];
  assign ex_reg_write  = exCtrl[C_REG_WRITE];
  assign ex_mem_read   = exCtrl[C_MEM_READ];
  assign ex_mem_write  = exCtrl[C_MEM_WRITE];
  assign ex_branch     = exCtrl[C_BRANCH];
  assign ex_jump       = exCtrl[C_JUMP];
  assign ex_sign_zero  = exCtrl[C_SIGN_ZERO];
  assign ex_alu_op     = exCtrl[C_ALU_OP_HI:C_ALU_OP_LO];
  assign ex_rd1        = rd1Q;
  assign ex_rd2        = rd2Q;
  assign ex_imm        = immQ;
  assign ex_pc4        = pc4Q;
  assign ex_rs         = rsQ;
  assign ex_rt         = rtQ;
  assign ex_rd         = rdQ;
  assign stall_count   = stallCnt;

endmodule
